// File: rtl/sd_block_writer.sv
// sd_block_writer: streams num_blocks x BLOCK_BYTES from a 1-cycle-latency source BRAM
// into the SD controller write port. Optional stall watchdog: define SD_WRITE_TIMEOUT_EN.
module sd_block_writer #(
  parameter int BLOCK_BYTES    = 512,
  parameter int SRC_AW         = 19,
  parameter bit BYTE_ADDRESSED = 1'b1,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [15:0]       num_blocks,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [7:0]        src_data,
  input  logic              sd_ready,
  input  logic              sd_ready_for_next_byte,
  output logic              sd_wr,
  output logic [7:0]        sd_din,
  output logic [31:0]       sd_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       blocks_written
);
  localparam int BC_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BLOCK_BYTES - 1);
  localparam logic [31:0] ADDR_STEP = BYTE_ADDRESSED ? 32'(BLOCK_BYTES) : 32'd1;

  typedef enum logic [2:0] {
    IDLE, PREFETCH_ADDR, PREFETCH_DATA, WAIT_RDY, ISSUE, STREAM, WAIT_DONE, FINISH
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       base_reg, base_next;
  logic [15:0]       num_reg, num_next;
  logic [15:0]       blk_reg, blk_next;
  logic [BC_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [SRC_AW-1:0] src_addr_reg, src_addr_next;
  logic [7:0]        din_reg, din_next;
  logic [31:0]       sd_addr_reg, sd_addr_next;
  logic              wr_reg, wr_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              req_prev_reg;
  logic [1:0]        load_reg, load_next;
  logic              req_edge;

  assign req_edge = sd_ready_for_next_byte & ~req_prev_reg;

`ifdef SD_WRITE_TIMEOUT_EN
  localparam logic [24:0] WD_LIMIT = 25'(TIMEOUT_CYCLES - 1);
  logic [24:0] wd_reg, wd_next;
  logic        err_reg, err_next;

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      wd_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      wd_reg  <= wd_next;
      err_reg <= err_next;
    end
  end

  assign error = err_reg;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    num_next      = num_reg;
    blk_next      = blk_reg;
    byte_cnt_next = byte_cnt_reg;
    src_addr_next = src_addr_reg;
    din_next      = din_reg;
    sd_addr_next  = sd_addr_reg;
    wr_next       = wr_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    // load_reg tracks a byte request through address update -> BRAM read -> sd_din
    load_next     = {load_reg[0], 1'b0};
`ifdef SD_WRITE_TIMEOUT_EN
    wd_next       = '0;
    err_next      = err_reg;
`endif
    if (load_reg[1])
      din_next = src_data;

    case (state_reg)
      IDLE: begin
        if (start) begin
          base_next     = base_addr;
          num_next      = num_blocks;
          blk_next      = '0;
          byte_cnt_next = '0;
          src_addr_next = '0;
          busy_next     = 1'b1;
          load_next     = '0;
`ifdef SD_WRITE_TIMEOUT_EN
          err_next      = 1'b0;
`endif
          state_next    = (num_blocks == 16'd0) ? FINISH : PREFETCH_ADDR;
        end
      end
      PREFETCH_ADDR: state_next = PREFETCH_DATA;
      PREFETCH_DATA: begin
        din_next   = src_data;
        state_next = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (sd_ready) begin
          sd_addr_next = base_reg + 32'(blk_reg) * ADDR_STEP;
          wr_next      = 1'b1;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        if (!sd_ready) begin
          wr_next    = 1'b0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (req_edge) begin
          src_addr_next = src_addr_reg + SRC_AW'(1);
          if (byte_cnt_reg == LAST_BYTE) begin
            // the next block's first byte is fetched by PREFETCH, not here
            byte_cnt_next = '0;
            state_next    = WAIT_DONE;
          end else begin
            byte_cnt_next = byte_cnt_reg + BC_W'(1);
            load_next[0]  = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (sd_ready) begin
          blk_next   = blk_reg + 16'd1;
          state_next = (blk_reg + 16'd1 == num_reg) ? FINISH : PREFETCH_ADDR;
        end
      end
      FINISH: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

`ifdef SD_WRITE_TIMEOUT_EN
    if (state_reg inside {WAIT_RDY, ISSUE, STREAM, WAIT_DONE}) begin
      if (state_next != state_reg || req_edge) begin
        wd_next = '0;
      end else if (wd_reg == WD_LIMIT) begin
        err_next   = 1'b1;
        wr_next    = 1'b0;
        load_next  = '0;
        state_next = FINISH;
      end else begin
        wd_next = wd_reg + 25'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      num_reg      <= '0;
      blk_reg      <= '0;
      byte_cnt_reg <= '0;
      src_addr_reg <= '0;
      din_reg      <= '0;
      sd_addr_reg  <= '0;
      wr_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      req_prev_reg <= 1'b0;
      load_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      num_reg      <= num_next;
      blk_reg      <= blk_next;
      byte_cnt_reg <= byte_cnt_next;
      src_addr_reg <= src_addr_next;
      din_reg      <= din_next;
      sd_addr_reg  <= sd_addr_next;
      wr_reg       <= wr_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      req_prev_reg <= sd_ready_for_next_byte;
      load_reg     <= load_next;
    end
  end

  assign src_addr       = src_addr_reg;
  assign sd_wr          = wr_reg;
  assign sd_din         = din_reg;
  assign sd_addr        = sd_addr_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign blocks_written = blk_reg;

endmodule

// File: doc/sd_block_writer.md
Name: sd_block_writer

Overview:
- Drives the write side of the SD SPI controller, which is currently tied off, so that processed data can be dumped to the card. Examples of such data are the edge/bin BRAM and FFT amplitude output.
- Streams `num_blocks` × 512-byte blocks from a single-port, 1-cycle-latency source BRAM to consecutive card blocks.
- Sits beside the existing SD read path. A top-level mux grants `sd_addr` to either the reader or this writer.

Parameters:
- BLOCK_BYTES, 512, bytes per SD block; must be a power of two.
- SRC_AW, 19, source BRAM address width.
- BYTE_ADDRESSED, 1, controls the address sent to the card:
  - 1: `sd_addr` = `base_addr` + blk×BLOCK_BYTES (SDSC).
  - 0: `sd_addr` = `base_addr` + blk (SDHC).
- TIMEOUT_CYCLES, 25_000_000, watchdog limit; used only with SD_WRITE_TIMEOUT_EN.

Ports:
- clk_25mhz  in  1  system clock, same clock as sd_controller.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  32  first card address; latched on accepted start.
- num_blocks  in  16  block count; latched on accepted start.
- src_addr  out  SRC_AW  source BRAM read address.
- src_data  in  8  source BRAM data, valid 1 cycle after `src_addr`.
- sd_ready  in  1  controller idle/ready.
- sd_ready_for_next_byte  in  1  controller byte request.
- sd_wr  out  1  write-block command to the controller.
- sd_din  out  8  byte presented to the controller.
- sd_addr  out  32  card address for the current block.
- busy  out  1  high from accepted start until `done`.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky timeout flag; cleared on the next accepted start.
- blocks_written  out  16  count of completed blocks in the current transfer.

Behaviour:
- Reset values (`reset_n` = 0, asynchronous):
  - All outputs are 0.
  - State goes to IDLE.
  - Internal byte and block counters are 0.
  - Reset mid-transfer abandons the card transaction and drops `sd_wr` immediately. The system must re-initialise the controller afterwards.
- `sd_ready_for_next_byte` is edge-detected with a registered previous value. One rising edge equals one byte consumed.
- State machine:
  - IDLE: on `start`, latch `base_addr`/`num_blocks`, clear `blocks_written` and `error`, set `busy`, set `src_addr` = 0. If `num_blocks` = 0, go to FINISH; otherwise go to PREFETCH.
  - PREFETCH (2 cycles): issue the `src_addr` read, then register `src_data` into `sd_din`. Go to WAIT_RDY.
  - WAIT_RDY: hold until `sd_ready` = 1. Then drive `sd_addr` for block `blocks_written` and go to ISSUE.
  - ISSUE: assert `sd_wr`. Hold it until `sd_ready` = 0 (command accepted), then deassert `sd_wr` and go to STREAM.
  - STREAM: on each request rising edge:
    - byte_cnt++ and `src_addr`++.
    - The new byte is read from BRAM and registered into `sd_din` within 2 cycles.
    - `sd_din` is otherwise held stable. The controller takes ≥16 clocks per byte, so the next byte is always ready.
    - When byte_cnt reaches BLOCK_BYTES, clear byte_cnt and go to WAIT_DONE. Do not prefetch past the block end.
  - WAIT_DONE: wait for `sd_ready` = 1 (CRC/busy complete). Then `blocks_written`++ and:
    - if `blocks_written` = `num_blocks`, go to FINISH;
    - otherwise go to PREFETCH. `src_addr` continues linearly into the next block.
  - FINISH: pulse `done` for 1 cycle, clear `busy`, return to IDLE.
- Boundary and corner cases:
  - `start` while busy is ignored.
  - `src_addr` wraps modulo 2^SRC_AW with no error.
  - `sd_addr` addition wraps modulo 2^32.
  - Extra request edges in WAIT_RDY or WAIT_DONE are ignored.

Optional Feature:
- Macro: SD_WRITE_TIMEOUT_EN.
- With the macro defined:
  - A 25-bit watchdog counts cycles spent in WAIT_RDY, ISSUE, STREAM or WAIT_DONE without progress. Progress means a state change or a request edge.
  - At TIMEOUT_CYCLES the block sets `error` = 1, drops `sd_wr` and goes to FINISH, so `done` still pulses.
  - `blocks_written` shows the blocks completed before the stall.
- Without the macro: no watchdog logic, `error` is tied to 0, and the FSM can wait forever.

Test Plan:
- Single block, BYTE_ADDRESSED=1, `base_addr` = 0x0000_0400, `num_blocks` = 1, source[i] = i[7:0], controller model requests every 32 cycles → `sd_addr` = 0x400 and one `sd_wr` assertion; 512 bytes are captured equal to 0x00..0xFF,0x00..0xFF; one `done` pulse, `blocks_written` = 1, `busy` low afterwards.
- Three blocks, BYTE_ADDRESSED=0, `base_addr` = 100 → `sd_addr` sequence 100, 101, 102; captured bytes follow source addresses 0..1535 in order; `done` only after the third `sd_ready` return.
- `num_blocks` = 0 → `sd_wr` never asserted; `done` pulses within 2 cycles of `start`; `blocks_written` = 0.
- `start` pulsed again mid-STREAM, then `reset_n` pulled low at byte 200 → the second start has no effect; on reset, `sd_wr`/`busy`/`done` are 0 immediately; a new start after release begins at `src_addr` 0.
- `sd_ready` held low for 40 cycles after each block plus `sd_ready_for_next_byte` held high for 3 cycles → one byte counted per edge; no early `sd_wr` for the next block.
- SD_WRITE_TIMEOUT_EN defined, TIMEOUT_CYCLES = 1000, model stops requesting at byte 10 → `error` = 1 and `done` pulse about 1000 cycles later; `sd_wr` = 0; `blocks_written` = 0.
